// File: rtl/line_arb_pkg.sv
// rtl/line_arb_pkg.sv - shared types and defaults for the line drawer arbiter
package line_arb_pkg;

    localparam int DEF_COORD_W = 11;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] y1;
        logic [DEF_COORD_W-1:0] x1;
        logic [DEF_COORD_W-1:0] y0;
        logic [DEF_COORD_W-1:0] x0;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        ACK
    } arb_state_t;

endpackage

// File: rtl/line_arbiter_rr_picker.sv
// rtl/line_arbiter_rr_picker.sv - combinational round-robin scan starting at ptr_i
module rr_picker
    import line_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [PTR_W:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found_o && req_i[cand[PTR_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/line_arbiter.sv
// rtl/line_arbiter.sv - round-robin sharing of one line_drawer between segment requesters
module line_arbiter
    import line_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*4*COORD_W-1:0] seg_i,
    input  logic [NUM_REQ-1:0]         color_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       err_timeout_o,
    output logic                       busy_o,
    output logic                       ld_start_o,
    output logic [COORD_W-1:0]         ld_x0_o,
    output logic [COORD_W-1:0]         ld_y0_o,
    output logic [COORD_W-1:0]         ld_x1_o,
    output logic [COORD_W-1:0]         ld_y1_o,
    output logic                       ld_color_o,
    input  logic                       ld_done_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int SEG_W = 4 * COORD_W;

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               abort_q, abort_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               color_q, color_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [SEG_W-1:0]   seg_sel;
    logic               color_sel;
    logic [NUM_REQ-1:0] sel_onehot;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        seg_sel    = '0;
        color_sel  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                seg_sel   = seg_i[i*SEG_W +: SEG_W];
                color_sel = color_i[i];
            end
            sel_onehot[i] = (sel_q == PTR_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            timer_q  <= '0;
            abort_q  <= 1'b0;
            seg_q    <= '0;
            color_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            timer_q  <= timer_d;
            abort_q  <= abort_d;
            seg_q    <= seg_d;
            color_q  <= color_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        abort_d  = abort_q;
        seg_d    = seg_q;
        color_d  = color_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    seg_d   = seg_sel;
                    color_d = color_sel;
                    sel_d   = pick_idx;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                abort_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                // timer_q == 0 marks the first RUN cycle, where done may be left over from the last line
                if (timer_q != '0 && ld_done_i) begin
                    state_d = ACK;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    abort_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                rr_ptr_d = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign ld_start_o    = (state_q == START);
    assign grant_o       = busy_o ? sel_onehot : '0;
    assign ack_o         = (state_q == ACK) ? sel_onehot : '0;
    assign err_timeout_o = (state_q == ACK) && abort_q;
    assign ld_x0_o       = seg_q[0*COORD_W +: COORD_W];
    assign ld_y0_o       = seg_q[1*COORD_W +: COORD_W];
    assign ld_x1_o       = seg_q[2*COORD_W +: COORD_W];
    assign ld_y1_o       = seg_q[3*COORD_W +: COORD_W];
    assign ld_color_o    = color_q;

endmodule

// File: tb/tb_line_arbiter.sv
// tb/tb_line_arbiter.sv - directed self-checking bench for line_arbiter
module tb_line_arbiter;
    import line_arb_pkg::*;

    localparam int NR = 3;
    localparam int CW = DEF_COORD_W;
    localparam int SW = 4 * CW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*SW-1:0] seg;
    logic [NR-1:0]   color;
    logic            done;

    logic [NR-1:0]   grant, ack, grant_t, ack_t;
    logic            err, busy, start, color_o, err_t, busy_t, start_t, color_t;
    logic [CW-1:0]   x0, y0, x1, y1, x0_t, y0_t, x1_t, y1_t;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .TIMEOUT_CYC(2048)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .seg_i(seg), .color_i(color),
        .grant_o(grant), .ack_o(ack), .err_timeout_o(err), .busy_o(busy),
        .ld_start_o(start), .ld_x0_o(x0), .ld_y0_o(y0), .ld_x1_o(x1), .ld_y1_o(y1),
        .ld_color_o(color_o), .ld_done_i(done)
    );

    line_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .TIMEOUT_CYC(16)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .seg_i(seg), .color_i(color),
        .grant_o(grant_t), .ack_o(ack_t), .err_timeout_o(err_t), .busy_o(busy_t),
        .ld_start_o(start_t), .ld_x0_o(x0_t), .ld_y0_o(y0_t), .ld_x1_o(x1_t), .ld_y1_o(y1_t),
        .ld_color_o(color_t), .ld_done_i(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seg(input int i, input int ax0, input int ay0, input int ax1, input int ay1);
        seg_t s;
        s.x0 = CW'(ax0);
        s.y0 = CW'(ay0);
        s.x1 = CW'(ax1);
        s.y1 = CW'(ay1);
        seg[i*SW +: SW] = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        seg   = '0;
        color = '0;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, ack, err, busy, start, x0, y0, x1, y1, color_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b ack=%b err=%b busy=%b start=%b x0=%0d required all zero",
                     grant, ack, err, busy, start, x0);
        end
    endtask

    task automatic test_single();
        int starts;
        int early_ack;
        do_reset();
        set_seg(0, 80, 248, 400, 248);
        color = 3'b001;
        req   = 3'b001;
        tick();
        starts = int'(start);
        checks++;
        if (grant !== 3'b001 || start !== 1'b1) begin
            errors++;
            $display("FAIL single_start: grant=%b start=%b required 001/1", grant, start);
        end
        checks++;
        if (x0 !== 11'd80 || y0 !== 11'd248 || x1 !== 11'd400 || y1 !== 11'd248 || color_o !== 1'b1) begin
            errors++;
            $display("FAIL single_coords: %0d,%0d,%0d,%0d c=%b required 80,248,400,248 c=1",
                     x0, y0, x1, y1, color_o);
        end
        early_ack = 0;
        for (int c = 0; c < 321; c++) begin
            tick();
            starts += int'(start);
            if (ack !== '0) early_ack++;
        end
        checks++;
        if (early_ack != 0) begin
            errors++;
            $display("FAIL single_early_ack: %0d ack cycles before done required 0", early_ack);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        checks++;
        if (ack !== 3'b001 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b err=%b required 001/0", ack, err);
        end
        tick();
        starts += int'(start);
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL single_idle: busy=%b ack=%b required 0/000", busy, ack);
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL single_start_count: %0d required 1", starts);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_order [4];
        logic          acked;
        int            waited;
        exp_order[0] = 3'b001;
        exp_order[1] = 3'b010;
        exp_order[2] = 3'b100;
        exp_order[3] = 3'b001;
        do_reset();
        req   = 3'b111;
        acked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (start !== 1'b1 && waited < 20) begin
                if (ack !== '0) acked = 1'b1;
                tick();
                waited++;
            end
            checks++;
            if (start !== 1'b1 || grant !== exp_order[i] || !acked) begin
                errors++;
                $display("FAIL rr_grant_%0d: grant=%b start=%b prior_ack=%b required %b/1/1",
                         i, grant, start, acked, exp_order[i]);
            end
            acked = 1'b0;
            for (int c = 0; c < 5; c++) tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (ack !== exp_order[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL rr_ack_%0d: ack=%b err=%b required %b/0", i, ack, err, exp_order[i]);
            end
            if (ack !== '0) acked = 1'b1;
        end
        req = '0;
    endtask

    task automatic test_stale_done();
        logic [NR-1:0] seen [3];
        do_reset();
        done = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL idle_done: busy=%b ack=%b required 0/000", busy, ack);
        end
        req = 3'b010;
        tick();
        tick();
        seen[0] = ack;
        tick();
        seen[1] = ack;
        tick();
        seen[2] = ack;
        checks++;
        if (seen[0] !== '0 || seen[1] !== '0 || seen[2] !== 3'b010) begin
            errors++;
            $display("FAIL stale_done: ack c2=%b c3=%b c4=%b required 000/000/010",
                     seen[0], seen[1], seen[2]);
        end
        done = 1'b0;
        req  = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 3'b001;
        tick();
        for (int c = 0; c < 16; c++) tick();
        checks++;
        if (ack_t !== '0 || busy_t !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: ack=%b busy=%b required 000/1", ack_t, busy_t);
        end
        req = 3'b011;
        tick();
        checks++;
        if (ack_t !== 3'b001 || err_t !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ack: ack=%b err=%b required 001/1", ack_t, err_t);
        end
        tick();
        tick();
        checks++;
        if (grant_t !== 3'b010 || start_t !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rr_advance: grant=%b start=%b required 010/1", grant_t, start_t);
        end
        req = '0;
    endtask

    task automatic test_mid_reset();
        int stray_ack;
        do_reset();
        set_seg(2, 7, 9, 300, 500);
        req = 3'b100;
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 3'b100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: grant=%b busy=%b required 100/1", grant, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, ack, err, busy, start, x0, y0, x1, y1, color_o} !== '0) begin
            errors++;
            $display("FAIL midreset_async: grant=%b ack=%b busy=%b x0=%0d required all zero",
                     grant, ack, busy, x0);
        end
        done = 1'b1;
        stray_ack = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack !== '0) stray_ack++;
        end
        done  = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b100 || start !== 1'b1 || stray_ack != 0 || x0 !== 11'd7) begin
            errors++;
            $display("FAIL midreset_restart: grant=%b start=%b stray_ack=%0d x0=%0d required 100/1/0/7",
                     grant, start, stray_ack, x0);
        end
        req = '0;
    endtask

    task automatic test_input_stability();
        do_reset();
        set_seg(0, 10, 20, 30, 40);
        color = 3'b001;
        req   = 3'b001;
        tick();
        set_seg(0, 5, 5, 5, 5);
        color = 3'b000;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (x0 !== 11'd10 || y0 !== 11'd20 || x1 !== 11'd30 || y1 !== 11'd40 || color_o !== 1'b1) begin
            errors++;
            $display("FAIL stable_latch: %0d,%0d,%0d,%0d c=%b required 10,20,30,40 c=1",
                     x0, y0, x1, y1, color_o);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        checks++;
        if (start !== 1'b1 || grant !== 3'b001 || x0 !== 11'd5 || y0 !== 11'd5 ||
            x1 !== 11'd5 || y1 !== 11'd5 || color_o !== 1'b0) begin
            errors++;
            $display("FAIL degenerate_grant: start=%b grant=%b %0d,%0d,%0d,%0d c=%b required 1/001 5,5,5,5 c=0",
                     start, grant, x0, y0, x1, y1, color_o);
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        checks++;
        if (ack !== 3'b001) begin
            errors++;
            $display("FAIL degenerate_ack: ack=%b required 001", ack);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_done();
        test_timeout();
        test_mid_reset();
        test_input_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
